// File: rtl/subleq_sequencer_pkg.sv
// Purpose : shared types, state codes and the instruction field helper for the SUBLEQ sequencer.
// Latency : n/a (declarations only).
// Backpress: n/a.
// Contents: WORD_W data width, DEF_ADDR_W address field width, FSM state codes,
//           insn_t instruction layout {c,b,a} and insn_field() extractor.
package subleq_sequencer_pkg;

  localparam int WORD_W     = 64;
  localparam int DEF_ADDR_W = 21;

  // FSM state codes
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  // Instruction word layout at the default address width, A in the LSBs.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] c;
    logic [DEF_ADDR_W-1:0] b;
    logic [DEF_ADDR_W-1:0] a;
  } insn_t;

  // Returns field idx (0=A, 1=B, 2=C) of an instruction word, already
  // zero-extended to a full word so it can drive a memory address directly.
  function automatic logic [WORD_W-1:0] insn_field(input logic [WORD_W-1:0] w,
                                                   input int unsigned       idx,
                                                   input int unsigned       aw);
    logic [WORD_W-1:0] mask;
    mask = (WORD_W'(1) << aw) - WORD_W'(1);
    return (w >> (idx * aw)) & mask;
  endfunction

endpackage

// File: rtl/subleq_sequencer_if.sv
// Purpose : bundle of the two memory ports driven by the sequencer.
// Latency : memory returns read data one cycle after the address.
// Backpress: none; the memory always accepts an access every cycle.
// Signals : add1/dataIn1/write1/dataOut1 (port 1), add2/dataIn2/write2/dataOut2 (port 2).
interface subleq_sequencer_if
  import subleq_sequencer_pkg::*;
#(
  parameter int W = WORD_W
);

  logic [W-1:0] add1;
  logic [W-1:0] dataIn1;
  logic         write1;
  logic [W-1:0] dataOut1;
  logic [W-1:0] add2;
  logic [W-1:0] dataIn2;
  logic         write2;
  logic [W-1:0] dataOut2;

  // Sequencer side
  modport master (
    output add1, dataIn1, write1, add2, dataIn2, write2,
    input  dataOut1, dataOut2
  );

  // Memory side
  modport slave (
    input  add1, dataIn1, write1, add2, dataIn2, write2,
    output dataOut1, dataOut2
  );

endinterface

// File: rtl/subleq_sequencer.sv
// Purpose : control FSM executing SUBLEQ out of a shared dual-port memory (fetch, operands, write-back, branch).
// Latency : exactly 3 cycles per instruction (FETCH, DECODE, EXEC); start to first write-back is 3 cycles.
// Backpress: none; no stall input, memory is assumed to accept every access.
// Ports   : clk, rst (sync, active-high), start pulse; mem = memory bus (master);
//           busy/halted/timeout status, pc, insn_count (retired since last start).
module subleq_sequencer
  import subleq_sequencer_pkg::*;
#(
  parameter int unsigned     START_PC  = 10,
  parameter int unsigned     ADDR_W    = DEF_ADDR_W,
  parameter longint unsigned MAX_INSNS = 64'd1 << 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  subleq_sequencer_if.master        mem,
  output logic                      busy,
  output logic                      halted,
  output logic                      timeout,
  output logic [ADDR_W-1:0]         pc,
  output logic [31:0]               insn_count
);

  logic [2:0]        state;
  logic [WORD_W-1:0] ir;

  logic [WORD_W-1:0] diff;
  logic              leq;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [31:0]       count_nxt;
  logic              wd_hit;

  // EXEC datapath: operands arrive from the reads issued in DECODE.
  assign diff      = mem.dataOut2 - mem.dataOut1;
  assign leq       = diff[WORD_W-1] | (diff == '0);
  assign target    = ADDR_W'(insn_field(ir, 2, ADDR_W));
  assign pc_inc    = pc + ADDR_W'(1);
  assign count_nxt = (insn_count == '1) ? insn_count : insn_count + 32'd1;
  // Compare in 33 bits so a watchdog limit of 2**32 can never alias to 0.
  assign wd_hit    = (({1'b0, insn_count} + 33'd1) == 33'(MAX_INSNS));

  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
  assign halted = (state == S_HALT);

  // Memory port drive. Port 1 only ever reads; port 2 reads B in DECODE and
  // writes B in EXEC, so it never sees a read and a write together.
  always_comb begin
    mem.add1    = '0;
    mem.dataIn1 = '0;
    mem.write1  = 1'b0;
    mem.add2    = '0;
    mem.dataIn2 = '0;
    mem.write2  = 1'b0;
    case (state)
      S_FETCH: begin
        mem.add1 = WORD_W'(pc);
      end
      S_DECODE: begin
        mem.add1 = insn_field(mem.dataOut1, 0, ADDR_W);
        mem.add2 = insn_field(mem.dataOut1, 1, ADDR_W);
      end
      S_EXEC: begin
        mem.add1    = insn_field(ir, 0, ADDR_W);
        mem.add2    = insn_field(ir, 1, ADDR_W);
        mem.dataIn2 = diff;
        // Reset wins over an in-flight write-back.
        mem.write2  = !rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= ADDR_W'(START_PC);
      insn_count <= '0;
      timeout    <= 1'b0;
      ir         <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state      <= S_FETCH;
            pc         <= ADDR_W'(START_PC);
            insn_count <= '0;
            timeout    <= 1'b0;
          end
        end
        S_FETCH: begin
          state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= mem.dataOut1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          pc         <= leq ? target : pc_inc;
          insn_count <= count_nxt;
          // Self-loop halt takes priority over the watchdog.
          if (leq && (target == pc)) begin
            state <= S_HALT;
          end else if (wd_hit) begin
            state   <= S_HALT;
            timeout <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Purpose : directed self-checking bench for subleq_sequencer with a 64-word dual-port memory model.
// Latency : memory model returns read data one cycle after the address; writes visible next cycle.
// Backpress: none.
module tb_subleq_sequencer;
  import subleq_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, halted, timeout;
  logic [20:0] pc;
  logic [31:0] insn_count;

  logic        clr = 1'b1;
  logic        pl_we = 1'b0;
  logic [5:0]  pl_addr = '0;
  logic [63:0] pl_dat = '0;
  logic        oob = 1'b0;
  logic [63:0] mem [64];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk = ~clk;

  subleq_sequencer_if #(.W(64)) mif ();

  subleq_sequencer #(
    .START_PC (10),
    .ADDR_W   (21),
    .MAX_INSNS(64'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem       (mif),
    .busy      (busy),
    .halted    (halted),
    .timeout   (timeout),
    .pc        (pc),
    .insn_count(insn_count)
  );

  // Dual-port memory: registered reads, writes land at the clock edge.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (pl_we) begin
      mem[pl_addr] <= pl_dat;
    end
    if (mif.write1) mem[mif.add1[5:0]] <= mif.dataIn1;
    if (mif.write2) mem[mif.add2[5:0]] <= mif.dataIn2;
    if ((|mif.add1[63:6]) || (|mif.add2[63:6])) oob <= 1'b1;
    mif.dataOut1 <= mem[mif.add1[5:0]];
    mif.dataOut2 <= mem[mif.add2[5:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int a, input int b, input int c);
    insn_t t;
    t.a = 21'(a);
    t.b = 21'(b);
    t.c = 21'(c);
    return 64'(t);
  endfunction

  task automatic preload(input int addr, input logic [63:0] dat);
    pl_we   = 1'b1;
    pl_addr = 6'(addr);
    pl_dat  = dat;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts busy cycles until halted, bounded so a stuck DUT cannot hang.
  task automatic run_to_halt(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 400 && !halted; k++) begin
      if (busy) busy_cycles++;
      tick();
    end
  endtask

  initial begin
    // 1: reset state
    tick();
    tick();
    check("rst_busy",   64'(busy),       64'd0);
    check("rst_halted", 64'(halted),     64'd0);
    check("rst_pc",     64'(pc),         64'd10);
    check("rst_count",  64'(insn_count), 64'd0);
    check("rst_write1", 64'(mif.write1), 64'd0);
    check("rst_write2", 64'(mif.write2), 64'd0);
    rst = 1'b0;
    clr = 1'b0;

    // 2: basic instruction, no branch
    preload(1, 64'd1);
    preload(3, 64'd3);
    preload(10, mk(1, 3, 20));
    pulse_start();
    check("t2_fetch_busy", 64'(busy), 64'd1);
    check("t2_fetch_add1", mif.add1,  64'd10);
    tick();
    check("t2_dec_add1", mif.add1, 64'd1);
    check("t2_dec_add2", mif.add2, 64'd3);
    tick();
    check("t2_exec_write2",  64'(mif.write2), 64'd1);
    check("t2_exec_add2",    mif.add2,        64'd3);
    check("t2_exec_dataIn2", mif.dataIn2,     64'd2);
    check("t2_exec_write1",  64'(mif.write1), 64'd0);
    check("t2_exec_dataIn1", mif.dataIn1,     64'd0);
    tick();
    check("t2_pc",    64'(pc),         64'd11);
    check("t2_count", 64'(insn_count), 64'd1);
    check("t2_mem3",  mem[3],          64'd2);
    do_reset();

    // 3: negative result, branch taken; then zero words branch 30 -> 0 -> self-halt
    preload(4, 64'd4);
    preload(2, 64'd2);
    preload(10, mk(4, 2, 30));
    pulse_start();
    tick();
    tick();
    check("t3_exec_dataIn2", mif.dataIn2, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check("t3_pc",   64'(pc), 64'd30);
    check("t3_mem2", mem[2],  64'hFFFF_FFFF_FFFF_FFFE);
    run_to_halt(cyc);
    check("t3_halted",  64'(halted),     64'd1);
    check("t3_pc_end",  64'(pc),         64'd0);
    check("t3_count",   64'(insn_count), 64'd3);
    check("t3_timeout", 64'(timeout),    64'd0);
    do_reset();

    // 4: A==B self-loop halt, then restart from HALT
    preload(5, 64'd7);
    preload(10, mk(5, 5, 10));
    pulse_start();
    run_to_halt(cyc);
    check("t4_cycles",  64'(cyc),        64'd3);
    check("t4_halted",  64'(halted),     64'd1);
    check("t4_timeout", 64'(timeout),    64'd0);
    check("t4_count",   64'(insn_count), 64'd1);
    check("t4_mem5",    mem[5],          64'd0);
    check("t4_pc",      64'(pc),         64'd10);
    preload(5, 64'd9);
    pulse_start();
    check("t4_re_busy",  64'(busy),       64'd1);
    check("t4_re_add1",  mif.add1,        64'd10);
    check("t4_re_count", 64'(insn_count), 64'd0);
    run_to_halt(cyc);
    check("t4_re_cycles", 64'(cyc),        64'd3);
    check("t4_re_mem5",   mem[5],          64'd0);
    check("t4_re_count2", 64'(insn_count), 64'd1);
    do_reset();

    // 5: non-halting loop 10 -> 11 -> 10 ... stopped by the watchdog (limit 4)
    preload(40, 64'd0);
    preload(41, 64'd5);
    preload(42, 64'd0);
    preload(43, 64'd0);
    preload(10, mk(40, 41, 50));
    preload(11, mk(42, 43, 10));
    pulse_start();
    run_to_halt(cyc);
    check("t5_cycles",  64'(cyc),        64'd12);
    check("t5_halted",  64'(halted),     64'd1);
    check("t5_timeout", 64'(timeout),    64'd1);
    check("t5_count",   64'(insn_count), 64'd4);
    check("t5_pc",      64'(pc),         64'd10);
    tick();
    check("t5_timeout_sticky", 64'(timeout), 64'd1);
    pulse_start();
    check("t5_timeout_clr", 64'(timeout), 64'd0);
    do_reset();

    // 6: reset during EXEC suppresses the write-back
    preload(1, 64'd1);
    preload(3, 64'd3);
    preload(10, mk(1, 3, 20));
    pulse_start();
    tick();
    tick();
    check("t6_exec_write2", 64'(mif.write2), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_write2", 64'(mif.write2), 64'd0);
    tick();
    rst = 1'b0;
    check("t6_mem3",   mem[3],          64'd3);
    check("t6_busy",   64'(busy),       64'd0);
    check("t6_halted", 64'(halted),     64'd0);
    check("t6_pc",     64'(pc),         64'd10);
    check("t6_count",  64'(insn_count), 64'd0);
    tick();
    check("t6_idle_busy", 64'(busy), 64'd0);

    check("addr_range", 64'(oob), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
